// File: rtl/xcorr_peak.sv
// xcorr_peak: windowed cross-correlation sweep over lags -MAX_LAG..+MAX_LAG
// with a saturated result stream and peak tracking on acc or |acc|.
module xcorr_peak #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_LAG        = 16,
  parameter int WIN_LEN        = 256,
  parameter int OUT_ADDR_WIDTH = 6,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int SHIFT          = 8,
  localparam int ACC_WIDTH     = 2*DATA_WIDTH+$clog2(WIN_LEN)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             peak_abs,
  output logic [ADDR_WIDTH-1:0]            a_addr,
  output logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic signed [DATA_WIDTH-1:0]     a_data,
  input  logic signed [DATA_WIDTH-1:0]     b_data,
  output logic [OUT_ADDR_WIDTH-1:0]        s_addr,
  output logic signed [OUT_DATA_WIDTH-1:0] s_data,
  output logic                             s_wren,
  output logic                             busy,
  output logic                             done,
  output logic signed [OUT_ADDR_WIDTH-1:0] peak_lag,
  output logic signed [ACC_WIDTH-1:0]      peak_val
);

  localparam int AW1 = ADDR_WIDTH+2;
  localparam int MW  = ACC_WIDTH+1;
  localparam int PW  = 2*DATA_WIDTH;
  localparam int OAW = OUT_ADDR_WIDTH;
  localparam int ODW = OUT_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t                      r_state;
  logic [ADDR_WIDTH-1:0]       r_i;
  logic signed [OAW-1:0]       r_k;
  logic                        r_cnt;
  logic                        r_abs;
  logic                        r_first;
  logic                        r_v1;
  logic                        r_v2;
  logic                        r_busy;
  logic                        r_done;
  logic signed [PW-1:0]        r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [OAW-1:0]       r_pk_lag;
  logic signed [ACC_WIDTH-1:0] r_pk_val;

  logic signed [AW1-1:0]       w_asum;
  logic signed [AW1-1:0]       w_bsum;
  logic signed [ACC_WIDTH-1:0] w_sh;
  logic signed [ODW-1:0]       w_sat;
  logic signed [MW-1:0]        w_ea;
  logic signed [MW-1:0]        w_ep;
  logic signed [MW-1:0]        w_m_acc;
  logic signed [MW-1:0]        w_m_pk;
  logic                        w_better;
  logic                        w_last_k;

  // read addresses: a walks the window, b is offset by the current lag
  assign w_asum = AW1'(MAX_LAG) + AW1'($signed({1'b0, r_i}));
  assign w_bsum = w_asum + AW1'(r_k);
  assign a_addr = w_asum[ADDR_WIDTH-1:0];
  assign b_addr = w_bsum[ADDR_WIDTH-1:0];

  assign w_sh = r_acc >>> SHIFT;

  generate
    if (ACC_WIDTH > ODW) begin : g_sat
      logic [ACC_WIDTH-ODW:0] w_hi;
      assign w_hi  = w_sh[ACC_WIDTH-1:ODW-1];
      assign w_sat = (&w_hi || ~|w_hi) ? w_sh[ODW-1:0] :
                     w_sh[ACC_WIDTH-1] ? {1'b1, {(ODW-1){1'b0}}} :
                                         {1'b0, {(ODW-1){1'b1}}};
    end else begin : g_nosat
      assign w_sat = ODW'(w_sh);
    end
  endgenerate

  // peak metric widened by one bit so |most negative| cannot wrap
  assign w_ea     = MW'(r_acc);
  assign w_ep     = MW'(r_pk_val);
  assign w_m_acc  = (r_abs && r_acc[ACC_WIDTH-1]) ? -w_ea : w_ea;
  assign w_m_pk   = (r_abs && r_pk_val[ACC_WIDTH-1]) ? -w_ep : w_ep;
  assign w_better = r_first || (w_m_acc > w_m_pk);
  assign w_last_k = (r_k >= OAW'(MAX_LAG));

  assign s_wren   = (r_state == S_WRITE);
  assign s_addr   = s_wren ? OAW'(r_k + OAW'(MAX_LAG)) : '0;
  assign s_data   = s_wren ? w_sat : '0;
  assign busy     = r_busy;
  assign done     = r_done;
  assign peak_lag = r_pk_lag;
  assign peak_val = r_pk_val;

  // multiply stage: product of the samples addressed one cycle earlier
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_prod <= '0;
    end else begin
      r_v1   <= (r_state == S_RUN);
      r_v2   <= r_v1;
      r_prod <= PW'(a_data) * PW'(b_data);
    end
  end

  // sweep controller, accumulator and peak tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_k      <= '0;
      r_cnt    <= 1'b0;
      r_abs    <= 1'b0;
      r_first  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_pk_lag <= '0;
      r_pk_val <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_v2) r_acc <= r_acc + ACC_WIDTH'(r_prod);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_k      <= -OAW'(MAX_LAG);
            r_i      <= '0;
            r_acc    <= '0;
            r_abs    <= peak_abs;
            r_first  <= 1'b1;
            r_pk_lag <= -OAW'(MAX_LAG);
            r_pk_val <= {1'b1, {(ACC_WIDTH-1){1'b0}}};
          end
        end
        S_RUN: begin
          r_i <= r_i + 1'b1;
          if (r_i == ADDR_WIDTH'(WIN_LEN-1)) begin
            r_state <= S_DRAIN;
            r_cnt   <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_cnt <= 1'b1;
          if (r_cnt) r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (w_better) begin
            r_pk_lag <= r_k;
            r_pk_val <= r_acc;
            r_first  <= 1'b0;
          end
          if (!w_last_k) begin
            r_state <= S_RUN;
            r_k     <= r_k + OAW'(1);
            r_i     <= '0;
            r_acc   <= '0;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
